// File: rtl/led_clksynth_monitor.sv
// Front-panel LED driver for the clock synthesizer: synchronises and debounces N_PLL lock-detect
// inputs, latches loss-of-lock events and drives the active-low red/green LED pair.
module led_clksynth_monitor #(
    parameter int N_PLL             = 2,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 1000,
    parameter int BLINK_HALF_PERIOD = 25000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_PLL-1:0] pll_ld,
    input  logic             clear_sticky,
    output logic             red_led,
    output logic             green_led,
    output logic             locked_all,
    output logic [N_PLL-1:0] lol_sticky,
    output logic [15:0]      lol_count,
    output logic [1:0]       fsm_state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int BW = $clog2(BLINK_HALF_PERIOD + 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_PERIOD - 1);

    // Encoding is {any_sticky, all_ok}, which is also what fsm_state reports.
    typedef enum logic [1:0] {
        ST_INIT      = 2'b00,
        ST_LOCKED    = 2'b01,
        ST_FAULT     = 2'b10,
        ST_RECOVERED = 2'b11
    } state_t;

    logic [N_PLL-1:0] db;
    logic [N_PLL-1:0] db_d;
    logic [N_PLL-1:0] fall;
    logic [N_PLL-1:0] sticky_next;
    logic [15:0]      count_next;
    logic [BW-1:0]    blink_cnt;
    logic             phase;
    logic             phase_next;
    logic             all_ok;
    logic             any_sticky;
    logic             red_next;
    logic             green_next;
    state_t           state;
    state_t           state_next;

    for (genvar i = 0; i < N_PLL; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CW-1:0]          cnt_q;
        logic                   db_q;

        // The counter restarts whenever the synchronised input agrees with the debounced value.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
                cnt_q  <= '0;
                db_q   <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], pll_ld[i]};
                if (sync_q[SYNC_STAGES-1] == db_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_LAST) begin
                    cnt_q <= '0;
                    db_q  <= ~db_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign db[i] = db_q;
    end

    always_comb begin
        fall        = db_d & ~db;
        sticky_next = (clear_sticky ? '0 : lol_sticky) | fall;
        if (clear_sticky)
            count_next = (|fall) ? 16'd1 : 16'd0;
        else if ((|fall) && (lol_count != 16'hFFFF))
            count_next = lol_count + 16'd1;
        else
            count_next = lol_count;
        all_ok     = &db;
        any_sticky = |sticky_next;
        phase_next = (blink_cnt == BLINK_LAST) ? ~phase : phase;
    end

    always_comb begin
        state_next = ST_INIT;
        red_next   = 1'b0;
        green_next = 1'b1;
        case ({any_sticky, all_ok})
            2'b00: state_next = ST_INIT;
            2'b01: state_next = ST_LOCKED;
            2'b10: state_next = ST_FAULT;
            default: state_next = ST_RECOVERED;
        endcase
        // LEDs use the next blink phase so they switch on the same edge as the phase.
        case (state_next)
            ST_INIT:   begin red_next = 1'b0;        green_next = 1'b1; end
            ST_LOCKED: begin red_next = 1'b1;        green_next = 1'b0; end
            ST_FAULT:  begin red_next = ~phase_next; green_next = 1'b1; end
            default:   begin red_next = ~phase_next; green_next = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_d       <= '0;
            lol_sticky <= '0;
            lol_count  <= 16'd0;
            state      <= ST_INIT;
            locked_all <= 1'b0;
            red_led    <= 1'b0;
            green_led  <= 1'b1;
            blink_cnt  <= '0;
            phase      <= 1'b0;
        end else begin
            db_d       <= db;
            lol_sticky <= sticky_next;
            lol_count  <= count_next;
            state      <= state_next;
            locked_all <= all_ok;
            red_led    <= red_next;
            green_led  <= green_next;
            blink_cnt  <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
            phase      <= phase_next;
        end
    end

    assign fsm_state = state;

endmodule
